// File: rtl/pump_sram_writer.sv
// SPI data-pump consumer: syncs byte strobes, queues them, and writes the async SRAM.
// Optional PUMP_CHECKSUM_EN adds a 16-bit running sum of written bytes.
module pump_sram_writer #(
  parameter int FIFO_DEPTH   = 4,
  parameter int SETUP_CYCLES = 1,
  parameter int WE_CYCLES    = 2,
  parameter int HOLD_CYCLES  = 1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        pump_active_i,
  input  logic [18:0] pump_a_i,
  input  logic [7:0]  pump_d_i,
  input  logic        pump_we_n_i,
  input  logic [18:0] core_a_i,
  input  logic [7:0]  core_d_i,
  input  logic        core_we_n_i,
  input  logic        core_oe_n_i,
  output logic [18:0] sram_a_o,
  output logic [7:0]  sram_d_o,
  output logic        sram_d_oe_o,
  output logic        sram_we_n_o,
  output logic        sram_oe_n_o,
  output logic        core_reset_n_o,
  output logic        busy_o,
  output logic        overflow_o,
  output logic [18:0] byte_count_o
`ifdef PUMP_CHECKSUM_EN
  ,
  output logic [15:0] checksum_o
`endif
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int TW = 16;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SETUP,
    S_WE,
    S_HOLD
  } state_t;

  logic pa_s1, pa_s2, pa_s3;
  logic we_s1, we_s2, we_s3;
  logic push, pa_rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pa_s1 <= 1'b0;
      pa_s2 <= 1'b0;
      pa_s3 <= 1'b0;
      we_s1 <= 1'b1;
      we_s2 <= 1'b1;
      we_s3 <= 1'b1;
    end else begin
      pa_s1 <= pump_active_i;
      pa_s2 <= pa_s1;
      pa_s3 <= pa_s2;
      we_s1 <= pump_we_n_i;
      we_s2 <= we_s1;
      we_s3 <= we_s2;
    end
  end

  assign push    = we_s3 & ~we_s2;
  assign pa_rise = pa_s2 & ~pa_s3;

  // FIFO entry is {addr, data}
  logic [26:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   cnt;
  logic          empty, full, push_ok, pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == (AW+1)'(FIFO_DEPTH));
  assign push_ok = push & ~full;

  always_ff @(posedge clk) begin
    if (push_ok)
      mem[wr_ptr] <= {pump_a_i, pump_d_i};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push_ok)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)
        cnt <= cnt + 1'b1;
      else if (!push_ok && pop)
        cnt <= cnt - 1'b1;
    end
  end

  state_t          state_q, state_d;
  logic [TW-1:0]   tmr_q, tmr_d;
  logic            done;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      tmr_q   <= '0;
    end else begin
      state_q <= state_d;
      tmr_q   <= tmr_d;
    end
  end

  always_comb begin
    state_d = state_q;
    tmr_d   = tmr_q;
    pop     = 1'b0;
    done    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_SETUP;
          tmr_d   = '0;
        end
      end
      S_SETUP: begin
        if (tmr_q == TW'(SETUP_CYCLES - 1)) begin
          state_d = S_WE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_WE: begin
        if (tmr_q == TW'(WE_CYCLES - 1)) begin
          state_d = S_HOLD;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      S_HOLD: begin
        if (tmr_q == TW'(HOLD_CYCLES - 1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
          done    = 1'b1;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        tmr_d   = '0;
      end
    endcase
  end

  // Bus drive registers track the next state so pins change aligned with it
  logic [18:0] a_q;
  logic [7:0]  d_q;
  logic        we_n_q, doe_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_q    <= '0;
      d_q    <= '0;
      we_n_q <= 1'b1;
      doe_q  <= 1'b0;
    end else begin
      if (pop)
        {a_q, d_q} <= mem[rd_ptr];
      we_n_q <= (state_d != S_WE);
      doe_q  <= (state_d != S_IDLE);
    end
  end

  logic        own_q, crst_q, ovf_q;
  logic [18:0] bc_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      own_q  <= 1'b0;
      crst_q <= 1'b0;
      ovf_q  <= 1'b0;
      bc_q   <= '0;
    end else begin
      crst_q <= ~own_q;
      if (pa_rise)
        own_q <= 1'b1;
      else if (!pa_s2 && empty && state_q == S_IDLE)
        own_q <= 1'b0;
      if (pa_rise)
        ovf_q <= 1'b0;
      else if (push && full)
        ovf_q <= 1'b1;
      if (pa_rise)
        bc_q <= '0;
      else if (done)
        bc_q <= bc_q + 1'b1;
    end
  end

`ifdef PUMP_CHECKSUM_EN
  logic [15:0] csum_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      csum_q <= '0;
    else if (pa_rise)
      csum_q <= '0;
    else if (done)
      csum_q <= csum_q + {8'h00, d_q};
  end

  assign checksum_o = csum_q;
`endif

  always_comb begin
    sram_a_o    = core_a_i;
    sram_d_o    = core_d_i;
    sram_we_n_o = core_we_n_i;
    sram_oe_n_o = core_oe_n_i;
    sram_d_oe_o = ~core_we_n_i;
    if (own_q) begin
      sram_a_o    = a_q;
      sram_d_o    = d_q;
      sram_we_n_o = we_n_q;
      sram_oe_n_o = 1'b1;
      sram_d_oe_o = doe_q;
    end
  end

  assign core_reset_n_o = crst_q;
  assign busy_o         = ~empty | (state_q != S_IDLE);
  assign overflow_o     = ovf_q;
  assign byte_count_o   = bc_q;

endmodule

// File: tb/tb_pump_sram_writer.sv
// Directed bench for pump_sram_writer: default instance plus a
// long-WE instance used to force FIFO overflow.
module tb_pump_sram_writer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        pump_active_i;
  logic [18:0] pump_a_i;
  logic [7:0]  pump_d_i;
  logic        pump_we_n_i;
  logic [18:0] core_a_i;
  logic [7:0]  core_d_i;
  logic        core_we_n_i;
  logic        core_oe_n_i;

  logic [18:0] sram_a_o;
  logic [7:0]  sram_d_o;
  logic        sram_d_oe_o, sram_we_n_o, sram_oe_n_o;
  logic        core_reset_n_o, busy_o, overflow_o;
  logic [18:0] byte_count_o;

  logic [18:0] s_a;
  logic [7:0]  s_d;
  logic        s_doe, s_we, s_oe, s_crst, s_busy, s_ovf;
  logic [18:0] s_bc;

`ifdef PUMP_CHECKSUM_EN
  logic [15:0] csum, s_csum;
`endif

  always #5 clk = ~clk;

  pump_sram_writer u_dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .pump_active_i  (pump_active_i),
    .pump_a_i       (pump_a_i),
    .pump_d_i       (pump_d_i),
    .pump_we_n_i    (pump_we_n_i),
    .core_a_i       (core_a_i),
    .core_d_i       (core_d_i),
    .core_we_n_i    (core_we_n_i),
    .core_oe_n_i    (core_oe_n_i),
    .sram_a_o       (sram_a_o),
    .sram_d_o       (sram_d_o),
    .sram_d_oe_o    (sram_d_oe_o),
    .sram_we_n_o    (sram_we_n_o),
    .sram_oe_n_o    (sram_oe_n_o),
    .core_reset_n_o (core_reset_n_o),
    .busy_o         (busy_o),
    .overflow_o     (overflow_o),
    .byte_count_o   (byte_count_o)
`ifdef PUMP_CHECKSUM_EN
    ,
    .checksum_o     (csum)
`endif
  );

  pump_sram_writer #(.WE_CYCLES(20)) u_slow (
    .clk            (clk),
    .reset_n        (reset_n),
    .pump_active_i  (pump_active_i),
    .pump_a_i       (pump_a_i),
    .pump_d_i       (pump_d_i),
    .pump_we_n_i    (pump_we_n_i),
    .core_a_i       (core_a_i),
    .core_d_i       (core_d_i),
    .core_we_n_i    (core_we_n_i),
    .core_oe_n_i    (core_oe_n_i),
    .sram_a_o       (s_a),
    .sram_d_o       (s_d),
    .sram_d_oe_o    (s_doe),
    .sram_we_n_o    (s_we),
    .sram_oe_n_o    (s_oe),
    .core_reset_n_o (s_crst),
    .busy_o         (s_busy),
    .overflow_o     (s_ovf),
    .byte_count_o   (s_bc)
`ifdef PUMP_CHECKSUM_EN
    ,
    .checksum_o     (s_csum)
`endif
  );

  int nasrt = 0;
  int nfail = 0;

  // WE# pulse recorder for the default instance
  int          np = 0;
  int          run = 0;
  logic [18:0] cap_a, pa [16];
  logic [7:0]  cap_d, pd [16];
  int          pl [16];

  always @(negedge clk) begin
    if (sram_we_n_o === 1'b0) begin
      run++;
      cap_a = sram_a_o;
      cap_d = sram_d_o;
    end else if (run > 0) begin
      if (np < 16) begin
        pa[np] = cap_a;
        pd[np] = cap_d;
        pl[np] = run;
      end
      np++;
      run = 0;
    end
  end

  int   s_np = 0;
  int   s_bad = 0;
  logic s_prev = 1'b1;

  always @(negedge clk) begin
    if (s_we === 1'b0 && s_prev === 1'b1) begin
      s_np++;
      if (s_d === 8'h66)
        s_bad++;
    end
    s_prev = s_we;
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    nasrt++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset_n       = 1'b0;
    pump_active_i = 1'b0;
    pump_we_n_i   = 1'b1;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic send_byte(input logic [18:0] a,
                           input logic [7:0] d);
    pump_a_i    = a;
    pump_d_i    = d;
    pump_we_n_i = 1'b0;
    repeat (8) @(negedge clk);
    pump_we_n_i = 1'b1;
    repeat (56) @(negedge clk);
  endtask

  task automatic strobe_fast(input logic [18:0] a,
                             input logic [7:0] d);
    pump_a_i    = a;
    pump_d_i    = d;
    pump_we_n_i = 1'b0;
    repeat (2) @(negedge clk);
    pump_we_n_i = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_release(input int lim);
    for (int i = 0; i < lim && core_reset_n_o !== 1'b1; i++)
      @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int base;

  initial begin
    reset_n       = 1'b0;
    pump_active_i = 1'b0;
    pump_a_i      = '0;
    pump_d_i      = '0;
    pump_we_n_i   = 1'b1;
    core_a_i      = 19'h12345;
    core_d_i      = 8'h3C;
    core_we_n_i   = 1'b0;
    core_oe_n_i   = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_crst", core_reset_n_o, 0);
    check("rst_busy", busy_o, 0);
    check("rst_ovf", overflow_o, 0);
    check("rst_bc", byte_count_o, 0);
    check("rst_we_pass", sram_we_n_o, 0);

    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("pass_crst", core_reset_n_o, 1);
    check("pass_a", sram_a_o, 32'h12345);
    check("pass_d", sram_d_o, 32'h3C);
    check("pass_we", sram_we_n_o, 0);
    check("pass_doe", sram_d_oe_o, 1);
    check("pass_oe", sram_oe_n_o, 1);

    // three bytes at SCK = clk/8
    core_we_n_i   = 1'b1;
    core_oe_n_i   = 1'b0;
    pump_active_i = 1'b1;
    repeat (6) @(negedge clk);
    check("start_crst", core_reset_n_o, 0);
    check("start_oe", sram_oe_n_o, 1);
    check("start_bc", byte_count_o, 0);
    base = np;
    send_byte(19'd0, 8'hA5);
    send_byte(19'd1, 8'h5A);
    send_byte(19'd2, 8'hFF);
    pump_active_i = 1'b0;
    wait_release(40);
    check("m_npulse", np - base, 3);
    check("m_len0", pl[base], 2);
    check("m_len1", pl[base+1], 2);
    check("m_len2", pl[base+2], 2);
    check("m_a0", pa[base], 0);
    check("m_d0", pd[base], 32'hA5);
    check("m_a1", pa[base+1], 1);
    check("m_d1", pd[base+1], 32'h5A);
    check("m_a2", pa[base+2], 2);
    check("m_d2", pd[base+2], 32'hFF);
    check("m_bc", byte_count_o, 3);
    check("m_crst", core_reset_n_o, 1);
    check("m_ovf", overflow_o, 0);

    // pump stop with bytes still queued
    do_reset();
    pump_active_i = 1'b1;
    repeat (6) @(negedge clk);
    base = np;
    strobe_fast(19'h00100, 8'h11);
    strobe_fast(19'h00101, 8'h22);
    strobe_fast(19'h00102, 8'h33);
    pump_active_i = 1'b0;
    @(negedge clk);
    check("dr_busy", busy_o, 1);
    check("dr_crst_lo", core_reset_n_o, 0);
    wait_release(100);
    check("dr_crst_hi", core_reset_n_o, 1);
    check("dr_npulse", np - base, 3);
    check("dr_busy_end", busy_o, 0);
    check("dr_bc", byte_count_o, 3);
    check("dr_a2", pa[base+2], 32'h00102);
    check("dr_d2", pd[base+2], 32'h33);

    // reset in the middle of a WE# pulse
    do_reset();
    pump_active_i = 1'b1;
    repeat (6) @(negedge clk);
    strobe_fast(19'h00200, 8'h44);
    for (int i = 0; i < 20 && sram_we_n_o !== 1'b0; i++)
      @(negedge clk);
    check("mr_we_lo", sram_we_n_o, 0);
    reset_n = 1'b0;
    #1;
    check("mr_we_core", sram_we_n_o, 1);
    check("mr_busy", busy_o, 0);
    check("mr_bc", byte_count_o, 0);
    check("mr_crst", core_reset_n_o, 0);
    core_we_n_i = 1'b0;
    #1;
    check("mr_we_follow", sram_we_n_o, 0);
    check("mr_doe", sram_d_oe_o, 1);
    core_we_n_i = 1'b1;
    pump_active_i = 1'b0;
    @(negedge clk);

    // overflow on the stalled instance
    do_reset();
    pump_active_i = 1'b1;
    repeat (6) @(negedge clk);
    base = s_np;
    strobe_fast(19'h00300, 8'h01);
    strobe_fast(19'h00301, 8'h02);
    strobe_fast(19'h00302, 8'h03);
    strobe_fast(19'h00303, 8'h04);
    strobe_fast(19'h00304, 8'h05);
    strobe_fast(19'h00305, 8'h66);
    for (int i = 0; i < 400 && s_busy !== 1'b0; i++)
      @(negedge clk);
    check("of_busy", s_busy, 0);
    check("of_ovf", s_ovf, 1);
    check("of_bc", s_bc, 5);
    check("of_npulse", s_np - base, 5);
    check("of_dropped", s_bad, 0);
    pump_active_i = 1'b0;
    repeat (10) @(negedge clk);
    pump_active_i = 1'b1;
    repeat (6) @(negedge clk);
    check("of_ovf_clr", s_ovf, 0);
    check("of_bc_clr", s_bc, 0);
    pump_active_i = 1'b0;
    repeat (10) @(negedge clk);

`ifdef PUMP_CHECKSUM_EN
    do_reset();
    pump_active_i = 1'b1;
    repeat (6) @(negedge clk);
    strobe_fast(19'h00400, 8'hFF);
    strobe_fast(19'h00401, 8'hFF);
    strobe_fast(19'h00402, 8'h03);
    pump_active_i = 1'b0;
    wait_release(100);
    check("cs_sum", csum, 32'h0201);
    pump_active_i = 1'b1;
    repeat (6) @(negedge clk);
    check("cs_clr", csum, 0);
    pump_active_i = 1'b0;
    repeat (10) @(negedge clk);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures",
             nasrt, nfail);
    $finish;
  end

endmodule
